// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the drawing pipeline and its checkers.
package vga_pkg;

  typedef logic [10:0] cnt_t;
  typedef logic [11:0] rgb_t;

  // Visible area
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  // Full frame timing including blanking and sync
  localparam int HOR_TOTAL = 1056;
  localparam int VER_TOTAL = 628;
  localparam int HS_START  = 840;
  localparam int HS_END    = 968;
  localparam int VS_START  = 601;
  localparam int VS_END    = 605;

  // Monitor lock state
  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } mon_state_t;

  // err_code bit positions
  localparam int ERR_W         = 3;
  localparam int ERR_COUNT_BIT = 0;
  localparam int ERR_SYNC_BIT  = 1;
  localparam int ERR_BLANK_BIT = 2;

  // Next value of a counter that runs 0 .. total-1 and then wraps.
  // Anything at or beyond the last value also wraps, so a bad load recovers.
  function automatic cnt_t wrap_inc(input cnt_t value, input int total);
    cnt_t last;
    last = cnt_t'(total - 1);
    if (value >= last) begin
      return '0;
    end
    return value + cnt_t'(1);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle: counters, sync/blank strobes and pixel colour.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount,
    input vcount,
    input hsync,
    input hblnk,
    input vsync,
    input vblnk,
    input rgb
  );

  modport out (
    output hcount,
    output vcount,
    output hsync,
    output hblnk,
    output vsync,
    output vblnk,
    output rgb
  );

endinterface

// File: rtl/vga_timing_model.sv
// Reference VGA timing: free-running h/v counters with a load port and the
// sync/blank levels a correct producer would drive at the current position.
module vga_timing_model #(
  parameter int HOR_PIXELS = vga_pkg::HOR_PIXELS,
  parameter int VER_PIXELS = vga_pkg::VER_PIXELS,
  parameter int HOR_TOTAL  = vga_pkg::HOR_TOTAL,
  parameter int VER_TOTAL  = vga_pkg::VER_TOTAL,
  parameter int HS_START   = vga_pkg::HS_START,
  parameter int HS_END     = vga_pkg::HS_END,
  parameter int VS_START   = vga_pkg::VS_START,
  parameter int VS_END     = vga_pkg::VS_END
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [10:0] load_h,
  input  logic [10:0] load_v,
  output logic [10:0] exp_h,
  output logic [10:0] exp_v,
  output logic        exp_hsync,
  output logic        exp_hblnk,
  output logic        exp_vsync,
  output logic        exp_vblnk
);

  import vga_pkg::*;

  cnt_t exp_h_reg;
  cnt_t exp_v_reg;
  logic h_last;

  assign h_last = (exp_h_reg >= cnt_t'(HOR_TOTAL - 1));

  // Advance one pixel per clock; a load overrides the count for resynchronisation
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_h_reg <= '0;
      exp_v_reg <= '0;
    end else if (load) begin
      exp_h_reg <= load_h;
      exp_v_reg <= load_v;
    end else begin
      exp_h_reg <= wrap_inc(exp_h_reg, HOR_TOTAL);
      if (h_last) begin
        exp_v_reg <= wrap_inc(exp_v_reg, VER_TOTAL);
      end
    end
  end

  // Expected strobes decoded straight from the model position
  always_comb begin
    exp_hsync = (exp_h_reg >= cnt_t'(HS_START)) && (exp_h_reg < cnt_t'(HS_END));
    exp_hblnk = (exp_h_reg >= cnt_t'(HOR_PIXELS));
    exp_vsync = (exp_v_reg >= cnt_t'(VS_START)) && (exp_v_reg < cnt_t'(VS_END));
    exp_vblnk = (exp_v_reg >= cnt_t'(VER_PIXELS));
  end

  assign exp_h = exp_h_reg;
  assign exp_v = exp_v_reg;

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker. Stage 1 samples the stream (and the probe
// coordinate alongside it); stage 2 compares the sample with the reference
// model, runs the lock FSM and registers every output.
module vga_timing_monitor #(
  parameter int HOR_PIXELS = vga_pkg::HOR_PIXELS,
  parameter int VER_PIXELS = vga_pkg::VER_PIXELS,
  parameter int HOR_TOTAL  = vga_pkg::HOR_TOTAL,
  parameter int VER_TOTAL  = vga_pkg::VER_TOTAL,
  parameter int HS_START   = vga_pkg::HS_START,
  parameter int HS_END     = vga_pkg::HS_END,
  parameter int VS_START   = vga_pkg::VS_START,
  parameter int VS_END     = vga_pkg::VS_END
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic [10:0] probe_h,
  input  logic [10:0] probe_v,
  output logic        locked,
  output logic        err_pulse,
  output logic [2:0]  err_code,
  output logic [15:0] err_count,
  output logic [15:0] frame_count,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
);

  import vga_pkg::*;

  // Stage 1 sample registers
  logic s1_valid_reg;
  cnt_t s1_h_reg;
  cnt_t s1_v_reg;
  logic s1_hsync_reg;
  logic s1_hblnk_reg;
  logic s1_vsync_reg;
  logic s1_vblnk_reg;
  rgb_t s1_rgb_reg;
  cnt_t s1_probe_h_reg;
  cnt_t s1_probe_v_reg;

  // Stage 2 state and output registers
  mon_state_t       state_reg;
  logic             locked_reg;
  logic             err_pulse_reg;
  logic [ERR_W-1:0] err_code_reg;
  logic [15:0]      err_count_reg;
  logic [15:0]      frame_count_reg;
  rgb_t             probe_rgb_reg;
  logic             probe_valid_reg;

  // Model interface
  cnt_t exp_h;
  cnt_t exp_v;
  logic exp_hsync;
  logic exp_hblnk;
  logic exp_vsync;
  logic exp_vblnk;
  logic model_load;

  // Stage 2 decisions
  logic [ERR_W-1:0] err_vec;
  logic             checking;
  logic             frame_start;
  logic             report_err;
  logic             probe_hit;

  // Capture the stream and probe coordinate together so they stay aligned.
  // The valid flag keeps the all-zero reset sample from looking like a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_h_reg       <= '0;
      s1_v_reg       <= '0;
      s1_hsync_reg   <= 1'b0;
      s1_hblnk_reg   <= 1'b0;
      s1_vsync_reg   <= 1'b0;
      s1_vblnk_reg   <= 1'b0;
      s1_rgb_reg     <= '0;
      s1_probe_h_reg <= '0;
      s1_probe_v_reg <= '0;
    end else begin
      s1_valid_reg   <= 1'b1;
      s1_h_reg       <= vga_in.hcount;
      s1_v_reg       <= vga_in.vcount;
      s1_hsync_reg   <= vga_in.hsync;
      s1_hblnk_reg   <= vga_in.hblnk;
      s1_vsync_reg   <= vga_in.vsync;
      s1_vblnk_reg   <= vga_in.vblnk;
      s1_rgb_reg     <= vga_in.rgb;
      s1_probe_h_reg <= probe_h;
      s1_probe_v_reg <= probe_v;
    end
  end

  // A frame start seen while searching seeds the model with the position of
  // the following sample, so model and sample line up from then on.
  assign model_load = s1_valid_reg && (state_reg == SEARCH) && frame_start;

  vga_timing_model #(
    .HOR_PIXELS (HOR_PIXELS),
    .VER_PIXELS (VER_PIXELS),
    .HOR_TOTAL  (HOR_TOTAL),
    .VER_TOTAL  (VER_TOTAL),
    .HS_START   (HS_START),
    .HS_END     (HS_END),
    .VS_START   (VS_START),
    .VS_END     (VS_END)
  ) u_model (
    .clk       (clk),
    .rst       (rst),
    .load      (model_load),
    .load_h    (11'd1),
    .load_v    (11'd0),
    .exp_h     (exp_h),
    .exp_v     (exp_v),
    .exp_hsync (exp_hsync),
    .exp_hblnk (exp_hblnk),
    .exp_vsync (exp_vsync),
    .exp_vblnk (exp_vblnk)
  );

  // Classify the current sample against the model
  always_comb begin
    err_vec                = '0;
    err_vec[ERR_COUNT_BIT] = (s1_h_reg != exp_h) || (s1_v_reg != exp_v);
    err_vec[ERR_SYNC_BIT]  = (s1_hsync_reg != exp_hsync) || (s1_vsync_reg != exp_vsync);
    err_vec[ERR_BLANK_BIT] = (s1_hblnk_reg != exp_hblnk) || (s1_vblnk_reg != exp_vblnk);
    frame_start            = (s1_h_reg == '0) && (s1_v_reg == '0);
    checking               = s1_valid_reg && ((state_reg == TRACK) || (state_reg == LOCKED));
    report_err             = checking && (|err_vec);
    // Out-of-range probes cannot hit: a sample that far out is already a count error
    probe_hit              = (s1_h_reg == s1_probe_h_reg) && (s1_v_reg == s1_probe_v_reg);
  end

  // Lock FSM with all outputs registered; an error always takes priority
  // over a frame start or a probe hit in the same sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= SEARCH;
      locked_reg      <= 1'b0;
      err_pulse_reg   <= 1'b0;
      err_code_reg    <= '0;
      err_count_reg   <= '0;
      frame_count_reg <= '0;
      probe_rgb_reg   <= '0;
      probe_valid_reg <= 1'b0;
    end else begin
      err_pulse_reg   <= 1'b0;
      probe_valid_reg <= 1'b0;

      if (report_err) begin
        err_pulse_reg <= 1'b1;
        err_code_reg  <= err_vec;
        if (err_count_reg != 16'hFFFF) begin
          err_count_reg <= err_count_reg + 16'd1;
        end
      end

      if (s1_valid_reg) begin
        case (state_reg)
          SEARCH: begin
            if (frame_start) begin
              state_reg <= TRACK;
            end
          end
          TRACK: begin
            if (report_err) begin
              state_reg <= SEARCH;
            end else if (frame_start) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
            end
          end
          LOCKED: begin
            if (report_err) begin
              state_reg  <= SEARCH;
              locked_reg <= 1'b0;
            end else begin
              if (frame_start) begin
                frame_count_reg <= frame_count_reg + 16'd1;
              end
              if (probe_hit) begin
                probe_rgb_reg   <= s1_rgb_reg;
                probe_valid_reg <= 1'b1;
              end
            end
          end
          default: begin
            state_reg  <= SEARCH;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked      = locked_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_code    = err_code_reg;
  assign err_count   = err_count_reg;
  assign frame_count = frame_count_reg;
  assign probe_rgb   = probe_rgb_reg;
  assign probe_valid = probe_valid_reg;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a shrunken 16x10 frame (160 clocks).
// The bench plays the producer: one pixel per clock driven on the falling edge,
// with optional one-shot or stuck faults. Outputs observed on a falling edge
// reflect the pixel driven two calls earlier.
module tb_vga_timing_monitor;

  localparam logic [10:0] T_HP    = 11'd10;
  localparam logic [10:0] T_HSS   = 11'd11;
  localparam logic [10:0] T_HSE   = 11'd13;
  localparam logic [10:0] T_HT    = 11'd16;
  localparam logic [10:0] T_VP    = 11'd6;
  localparam logic [10:0] T_VSS   = 11'd7;
  localparam logic [10:0] T_VSE   = 11'd8;
  localparam logic [10:0] T_VT    = 11'd10;
  localparam logic [10:0] T_HLAST = 11'd15;
  localparam logic [10:0] T_VLAST = 11'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] probe_h;
  logic [10:0] probe_v;
  logic        locked;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [15:0] err_count;
  logic [15:0] frame_count;
  logic [11:0] probe_rgb;
  logic        probe_valid;

  vga_if vif ();

  vga_timing_monitor #(
    .HOR_PIXELS (int'(T_HP)),
    .VER_PIXELS (int'(T_VP)),
    .HOR_TOTAL  (int'(T_HT)),
    .VER_TOTAL  (int'(T_VT)),
    .HS_START   (int'(T_HSS)),
    .HS_END     (int'(T_HSE)),
    .VS_START   (int'(T_VSS)),
    .VS_END     (int'(T_VSE))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vif),
    .probe_h     (probe_h),
    .probe_v     (probe_v),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .err_count   (err_count),
    .frame_count (frame_count),
    .probe_rgb   (probe_rgb),
    .probe_valid (probe_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Producer state and fault controls
  logic [10:0] gen_h = '0;
  logic [10:0] gen_v = '0;
  logic        skip_armed  = 1'b0;
  logic        hsync_armed = 1'b0;
  logic        hblnk_stuck = 1'b0;
  int          pix_idx = 0;

  // Observation accumulators
  logic [10:0] hist_h1 = '0;
  logic [10:0] hist_h2 = '0;
  logic        prev_locked = 1'b0;
  int          err_pulses = 0;
  int          probe_pulses = 0;
  int          lock_rise_idx = -1;
  int          first_err_h = -1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pixel %0d)", tag, act, exp, pix_idx);
    end
  endtask

  // Observe outputs, then drive one pixel and advance the producer
  task automatic drive_pix(input logic rst_val);
    logic hs;
    logic hb;
    @(negedge clk);
    if (err_pulse === 1'b1) begin
      err_pulses++;
      if (first_err_h < 0) first_err_h = int'(hist_h2);
    end
    if (probe_valid === 1'b1) probe_pulses++;
    if (locked === 1'b1 && prev_locked === 1'b0) lock_rise_idx = pix_idx;
    prev_locked = locked;

    if (skip_armed && gen_v == 11'd2 && gen_h == 11'd6) begin
      gen_h      = 11'd7;
      skip_armed = 1'b0;
    end
    hs = (gen_h >= T_HSS) && (gen_h < T_HSE);
    hb = (gen_h >= T_HP);
    if (hsync_armed && gen_h == 11'd12) begin
      hs          = 1'b0;
      hsync_armed = 1'b0;
    end
    if (hblnk_stuck) hb = 1'b0;

    rst        = rst_val;
    vif.hcount = gen_h;
    vif.vcount = gen_v;
    vif.hsync  = hs;
    vif.hblnk  = hb;
    vif.vsync  = (gen_v >= T_VSS) && (gen_v < T_VSE);
    vif.vblnk  = (gen_v >= T_VP);
    vif.rgb    = (gen_h == 11'd4 && gen_v == 11'd3) ? 12'hFF0 : {gen_h[3:0], gen_v[3:0], 4'hA};

    hist_h2 = hist_h1;
    hist_h1 = gen_h;
    if (gen_h == T_HLAST) begin
      gen_h = '0;
      gen_v = (gen_v == T_VLAST) ? 11'd0 : gen_v + 11'd1;
    end else begin
      gen_h = gen_h + 11'd1;
    end
    pix_idx++;
  endtask

  task automatic run_to(input int target);
    while (pix_idx < target) drive_pix(1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    probe_h    = 11'd4;
    probe_v    = 11'd3;
    vif.hcount = '0;
    vif.vcount = '0;
    vif.hsync  = 1'b0;
    vif.hblnk  = 1'b0;
    vif.vsync  = 1'b0;
    vif.vblnk  = 1'b0;
    vif.rgb    = '0;
    repeat (3) @(negedge clk);
    check_val("reset_all_outputs",
              {locked, err_pulse, err_code, err_count, frame_count, probe_rgb, probe_valid}, '0);
    check_val("reset_locked", locked, 1'b0);

    // Clean stream from a frame start: lock after the second frame start
    run_to(500);
    check_val("clean_lock_rise", lock_rise_idx, 162);
    check_val("clean_locked", locked, 1'b1);
    check_val("clean_frame_count", frame_count, 16'd2);
    check_val("clean_err_count", err_count, 16'd0);
    check_val("clean_err_pulses", err_pulses, 0);
    check_val("clean_probe_pulses", probe_pulses, 2);
    check_val("clean_probe_rgb", probe_rgb, 12'hFF0);

    // Skipped hcount on line 2: 5 -> 7
    skip_armed = 1'b1;
    first_err_h = -1;
    run_to(700);
    check_val("skip_err_pulses", err_pulses, 1);
    check_val("skip_err_h", first_err_h, 7);
    check_val("skip_err_code", err_code, 3'b001);
    check_val("skip_err_count", err_count, 16'd1);
    check_val("skip_unlocked", locked, 1'b0);
    run_to(810);
    check_val("skip_relock_idx", lock_rise_idx, 801);
    check_val("skip_frames_frozen", frame_count, 16'd2);

    // hsync dropped at hcount 12
    hsync_armed = 1'b1;
    run_to(1100);
    check_val("hsync_err_code", err_code, 3'b010);
    check_val("hsync_err_count", err_count, 16'd2);
    check_val("hsync_unlocked", locked, 1'b0);
    check_val("hsync_frames_frozen", frame_count, 16'd2);
    run_to(1290);
    check_val("hsync_relock_idx", lock_rise_idx, 1121);
    check_val("hsync_frame_resume", frame_count, 16'd3);

    // Probe outside the frame never fires
    probe_h = 11'd20;
    probe_pulses = 0;
    run_to(1490);
    check_val("probe_oor_pulses", probe_pulses, 0);
    check_val("probe_oor_rgb_held", probe_rgb, 12'hFF0);
    check_val("probe_oor_locked", locked, 1'b1);

    // One-cycle reset mid-frame while locked
    drive_pix(1'b1);
    @(posedge clk);
    #1;
    check_val("midrst_outputs",
              {locked, err_pulse, err_code, err_count, frame_count, probe_rgb, probe_valid}, '0);
    run_to(1800);
    check_val("midrst_relock_idx", lock_rise_idx, 1761);
    check_val("midrst_frame_count", frame_count, 16'd0);

    // hblnk stuck low with correct counters
    hblnk_stuck = 1'b1;
    first_err_h = -1;
    err_pulses  = 0;
    run_to(2300);
    check_val("hblnk_first_err_h", first_err_h, 10);
    check_val("hblnk_err_code", err_code, 3'b100);
    check_val("hblnk_err_pulses", err_pulses, 4);
    check_val("hblnk_err_count", err_count, 16'd4);
    check_val("hblnk_never_locks", lock_rise_idx, 1761);
    check_val("hblnk_unlocked", locked, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
